// File: rtl/multicycle_control_if.sv
// Control-unit bus: IR fields and memory handshake in, datapath controls and status out.
interface multicycle_control_if #(
   parameter int unsigned CNT_W = 16
) ();
   logic [6:0]       Opcode;
   logic [3:0]       Funct;
   logic             mem_ready;
   logic             pc_write;
   logic             ir_write;
   logic             i_or_d;
   logic             Branch;
   logic             MemRead;
   logic             MemWrite;
   logic             MemtoReg;
   logic             ALUSrc;
   logic             RegWrite;
   logic [3:0]       Operation;
   logic [2:0]       state;
   logic             instr_done;
   logic [CNT_W-1:0] instr_count;
   logic             trap;

   modport master (
      output Opcode, Funct, mem_ready,
      input  pc_write, ir_write, i_or_d, Branch, MemRead, MemWrite, MemtoReg, ALUSrc, RegWrite,
      input  Operation, state, instr_done, instr_count, trap
   );

   modport slave (
      input  Opcode, Funct, mem_ready,
      output pc_write, ir_write, i_or_d, Branch, MemRead, MemWrite, MemtoReg, ALUSrc, RegWrite,
      output Operation, state, instr_done, instr_count, trap
   );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle RISC-V control unit: sequences one instruction over 3-5 cycles around a shared
// memory and ALU, with memory-timeout and illegal-instruction traps and a retirement counter.
module multicycle_control #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 16
) (
   input logic                 clk,
   input logic                 rst_n,
   multicycle_control_if.slave bus
);

   localparam int unsigned WaitW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [WaitW-1:0] WaitMax = WaitW'(MEM_TIMEOUT);

   localparam logic [6:0] OpR     = 7'b0110011;
   localparam logic [6:0] OpI     = 7'b0010011;
   localparam logic [6:0] OpLoad  = 7'b0000011;
   localparam logic [6:0] OpStore = 7'b0100011;
   localparam logic [6:0] OpBeq   = 7'b1100011;

   localparam logic [3:0] AluAnd = 4'b0000;
   localparam logic [3:0] AluOr  = 4'b0001;
   localparam logic [3:0] AluAdd = 4'b0010;
   localparam logic [3:0] AluSub = 4'b0110;

   typedef enum logic [2:0] {
      StFetch   = 3'd0,
      StDecode  = 3'd1,
      StExecute = 3'd2,
      StMem     = 3'd3,
      StWb      = 3'd4,
      StTrap    = 3'd5
   } state_e;

   state_e           state_q, state_d;
   logic [6:0]       opcode_q;
   logic [3:0]       funct_q;
   logic [WaitW-1:0] wait_q, wait_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic       alu_ok;
   logic [3:0] alu_op;
   logic       timeout;
   logic       pc_write, ir_write, i_or_d, branch, mem_read, mem_write;
   logic       mem_to_reg, alu_src, reg_write, instr_done, trap;
   logic [3:0] operation;

   // ALU decode from the fields latched in DECODE; I-type ignores funct7.
   always_comb begin
      alu_ok = 1'b1;
      alu_op = AluAdd;
      if (opcode_q == OpR) begin
         case (funct_q)
            4'b0000: alu_op = AluAdd;
            4'b1000: alu_op = AluSub;
            4'b0111: alu_op = AluAnd;
            4'b0110: alu_op = AluOr;
            default: begin
               alu_ok = 1'b0;
               alu_op = 4'b0000;
            end
         endcase
      end else begin
         case (funct_q[2:0])
            3'b000:  alu_op = AluAdd;
            3'b111:  alu_op = AluAnd;
            3'b110:  alu_op = AluOr;
            default: begin
               alu_ok = 1'b0;
               alu_op = 4'b0000;
            end
         endcase
      end
   end

   always_comb begin
      wait_d  = '0;
      timeout = 1'b0;
      if ((state_q == StFetch || state_q == StMem) && !bus.mem_ready && MEM_TIMEOUT != 0) begin
         wait_d  = wait_q + WaitW'(1);
         timeout = (wait_d == WaitMax);
      end
   end

   // ir_write/pc_write and the store's instr_done follow mem_ready so they land on the
   // cycle the memory actually completes.
   always_comb begin
      state_d    = state_q;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      i_or_d     = 1'b0;
      branch     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      alu_src    = 1'b0;
      reg_write  = 1'b0;
      operation  = 4'b0000;
      instr_done = 1'b0;
      trap       = 1'b0;
      case (state_q)
         StFetch: begin
            mem_read  = 1'b1;
            operation = AluAdd;
            if (bus.mem_ready) begin
               pc_write = 1'b1;
               ir_write = 1'b1;
               state_d  = StDecode;
            end else if (timeout) begin
               state_d = StTrap;
            end
         end
         StDecode: begin
            case (bus.Opcode)
               OpR, OpI, OpLoad, OpStore, OpBeq: state_d = StExecute;
               default:                          state_d = StTrap;
            endcase
         end
         StExecute: begin
            case (opcode_q)
               OpR, OpI: begin
                  if (alu_ok) begin
                     alu_src   = (opcode_q == OpI);
                     operation = alu_op;
                     state_d   = StWb;
                  end else begin
                     state_d = StTrap;
                  end
               end
               OpLoad, OpStore: begin
                  alu_src   = 1'b1;
                  operation = AluAdd;
                  state_d   = StMem;
               end
               OpBeq: begin
                  operation  = AluSub;
                  branch     = 1'b1;
                  instr_done = 1'b1;
                  state_d    = StFetch;
               end
               default: state_d = StTrap;
            endcase
         end
         StMem: begin
            i_or_d    = 1'b1;
            mem_read  = (opcode_q == OpLoad);
            mem_write = (opcode_q == OpStore);
            if (bus.mem_ready) begin
               instr_done = (opcode_q == OpStore);
               state_d    = (opcode_q == OpLoad) ? StWb : StFetch;
            end else if (timeout) begin
               state_d = StTrap;
            end
         end
         StWb: begin
            reg_write  = 1'b1;
            mem_to_reg = (opcode_q == OpLoad);
            instr_done = 1'b1;
            state_d    = StFetch;
         end
         StTrap:  trap = 1'b1;
         default: state_d = StTrap;
      endcase
   end

   assign cnt_d = cnt_q + CNT_W'(instr_done);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StFetch;
         opcode_q <= '0;
         funct_q  <= '0;
         wait_q   <= '0;
         cnt_q    <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         cnt_q   <= cnt_d;
         if (state_q == StDecode) begin
            opcode_q <= bus.Opcode;
            funct_q  <= bus.Funct;
         end
      end
   end

   assign bus.pc_write    = pc_write;
   assign bus.ir_write    = ir_write;
   assign bus.i_or_d      = i_or_d;
   assign bus.Branch      = branch;
   assign bus.MemRead     = mem_read;
   assign bus.MemWrite    = mem_write;
   assign bus.MemtoReg    = mem_to_reg;
   assign bus.ALUSrc      = alu_src;
   assign bus.RegWrite    = reg_write;
   assign bus.Operation   = operation;
   assign bus.state       = state_q;
   assign bus.instr_done  = instr_done;
   assign bus.instr_count = cnt_q;
   assign bus.trap        = trap;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: stimulus pushes hand-computed per-cycle control vectors; a negedge monitor
// pops and compares them against two DUTs (default parameters, and a short timeout/counter).
module tb_multicycle_control;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_BAD   = 7'b1111111;

   // Control bit order: pc_write ir_write i_or_d Branch MemRead MemWrite MemtoReg ALUSrc RegWrite
   localparam logic [8:0] C_NONE   = 9'b000000000;
   localparam logic [8:0] C_FRDY   = 9'b110010000;
   localparam logic [8:0] C_FWAIT  = 9'b000010000;
   localparam logic [8:0] C_EXIMM  = 9'b000000010;
   localparam logic [8:0] C_EXBR   = 9'b000100000;
   localparam logic [8:0] C_MEMLD  = 9'b001010000;
   localparam logic [8:0] C_MEMST  = 9'b001001000;
   localparam logic [8:0] C_WBALU  = 9'b000000001;
   localparam logic [8:0] C_WBLD   = 9'b000000101;

   typedef struct packed {
      logic [2:0]  st;
      logic [8:0]  ctl;
      logic [3:0]  op;
      logic        done;
      logic        trap;
      logic [15:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst_na = 1'b0;
   logic rst_nb = 1'b0;
   int   checks = 0;
   int   errors = 0;
   exp_t q_a[$];
   exp_t q_b[$];
   exp_t exp_a, act_a, exp_b, act_b;

   always #5 clk = ~clk;

   multicycle_control_if #(.CNT_W(16)) a_if ();
   multicycle_control_if #(.CNT_W(2))  b_if ();

   multicycle_control #(.MEM_TIMEOUT(16), .CNT_W(16)) u_dut_a (
      .clk   (clk),
      .rst_n (rst_na),
      .bus   (a_if.slave)
   );

   multicycle_control #(.MEM_TIMEOUT(4), .CNT_W(2)) u_dut_b (
      .clk   (clk),
      .rst_n (rst_nb),
      .bus   (b_if.slave)
   );

   function automatic exp_t ex(input logic [2:0] st, input logic [8:0] ctl, input logic [3:0] op,
                               input logic done, input int cnt);
      exp_t e;
      e.st   = st;
      e.ctl  = ctl;
      e.op   = op;
      e.done = done;
      e.trap = (st == 3'd5);
      e.cnt  = cnt[15:0];
      return e;
   endfunction

   always @(negedge clk) begin
      if (q_a.size() > 0) begin
         exp_a = q_a.pop_front();
         act_a.st   = a_if.state;
         act_a.ctl  = {a_if.pc_write, a_if.ir_write, a_if.i_or_d, a_if.Branch, a_if.MemRead,
                       a_if.MemWrite, a_if.MemtoReg, a_if.ALUSrc, a_if.RegWrite};
         act_a.op   = a_if.Operation;
         act_a.done = a_if.instr_done;
         act_a.trap = a_if.trap;
         act_a.cnt  = a_if.instr_count;
         checks++;
         if (act_a !== exp_a) begin
            errors++;
            $display("FAIL dut_a t=%0t got st=%0d ctl=%b op=%b done=%b trap=%b cnt=%0d, want st=%0d ctl=%b op=%b done=%b trap=%b cnt=%0d",
                     $time, act_a.st, act_a.ctl, act_a.op, act_a.done, act_a.trap, act_a.cnt,
                     exp_a.st, exp_a.ctl, exp_a.op, exp_a.done, exp_a.trap, exp_a.cnt);
         end
      end
      if (q_b.size() > 0) begin
         exp_b = q_b.pop_front();
         act_b.st   = b_if.state;
         act_b.ctl  = {b_if.pc_write, b_if.ir_write, b_if.i_or_d, b_if.Branch, b_if.MemRead,
                       b_if.MemWrite, b_if.MemtoReg, b_if.ALUSrc, b_if.RegWrite};
         act_b.op   = b_if.Operation;
         act_b.done = b_if.instr_done;
         act_b.trap = b_if.trap;
         act_b.cnt  = 16'(b_if.instr_count);
         checks++;
         if (act_b !== exp_b) begin
            errors++;
            $display("FAIL dut_b t=%0t got st=%0d ctl=%b op=%b done=%b trap=%b cnt=%0d, want st=%0d ctl=%b op=%b done=%b trap=%b cnt=%0d",
                     $time, act_b.st, act_b.ctl, act_b.op, act_b.done, act_b.trap, act_b.cnt,
                     exp_b.st, exp_b.ctl, exp_b.op, exp_b.done, exp_b.trap, exp_b.cnt);
         end
      end
   end

   task automatic cyc(input bit sel, input logic [6:0] opc, input logic [3:0] fn,
                      input logic rdy, input exp_t e);
      @(posedge clk);
      #1;
      if (!sel) begin
         a_if.Opcode = opc; a_if.Funct = fn; a_if.mem_ready = rdy;
         q_a.push_back(e);
      end else begin
         b_if.Opcode = opc; b_if.Funct = fn; b_if.mem_ready = rdy;
         q_b.push_back(e);
      end
   endtask

   task automatic alu_instr(input logic [6:0] opc, input logic [3:0] fn, input logic [3:0] op,
                            input int cnt);
      logic [8:0] ex_ctl;
      ex_ctl = (opc == OP_I) ? C_EXIMM : C_NONE;
      cyc(0, opc, fn, 1'b1, ex(3'd0, C_FRDY, 4'b0010, 1'b0, cnt));
      cyc(0, opc, fn, 1'b1, ex(3'd1, C_NONE, 4'b0000, 1'b0, cnt));
      cyc(0, opc, fn, 1'b1, ex(3'd2, ex_ctl, op, 1'b0, cnt));
      cyc(0, opc, fn, 1'b1, ex(3'd4, C_WBALU, 4'b0000, 1'b1, cnt));
   endtask

   task automatic beq(input bit sel, input int cnt);
      cyc(sel, OP_BEQ, 4'b0000, 1'b1, ex(3'd0, C_FRDY, 4'b0010, 1'b0, cnt));
      cyc(sel, OP_BEQ, 4'b0000, 1'b1, ex(3'd1, C_NONE, 4'b0000, 1'b0, cnt));
      cyc(sel, OP_BEQ, 4'b0000, 1'b1, ex(3'd2, C_EXBR, 4'b0110, 1'b1, cnt));
   endtask

   task automatic reset_a();
      @(posedge clk);
      #3;
      a_if.mem_ready = 1'b0;
      rst_na = 1'b0;
      @(posedge clk);
      #3;
      rst_na = 1'b1;
   endtask

   initial begin
      a_if.Opcode = '0; a_if.Funct = '0; a_if.mem_ready = 1'b0;
      b_if.Opcode = '0; b_if.Funct = '0; b_if.mem_ready = 1'b0;
      #1;
      q_a.push_back(ex(3'd0, C_FWAIT, 4'b0010, 1'b0, 0));  // reset state
      #11;
      rst_na = 1'b1;

      // R ADD, R SUB
      alu_instr(OP_R, 4'b0000, 4'b0010, 0);
      alu_instr(OP_R, 4'b1000, 4'b0110, 1);

      // load with three memory stall cycles
      cyc(0, OP_LOAD, 4'b0010, 1'b1, ex(3'd0, C_FRDY, 4'b0010, 1'b0, 2));
      cyc(0, OP_LOAD, 4'b0010, 1'b1, ex(3'd1, C_NONE, 4'b0000, 1'b0, 2));
      cyc(0, OP_LOAD, 4'b0010, 1'b1, ex(3'd2, C_EXIMM, 4'b0010, 1'b0, 2));
      for (int i = 0; i < 3; i++)
         cyc(0, OP_LOAD, 4'b0010, 1'b0, ex(3'd3, C_MEMLD, 4'b0000, 1'b0, 2));
      cyc(0, OP_LOAD, 4'b0010, 1'b1, ex(3'd3, C_MEMLD, 4'b0000, 1'b0, 2));
      cyc(0, OP_LOAD, 4'b0010, 1'b1, ex(3'd4, C_WBLD, 4'b0000, 1'b1, 2));

      // store then beq
      cyc(0, OP_STORE, 4'b0010, 1'b1, ex(3'd0, C_FRDY, 4'b0010, 1'b0, 3));
      cyc(0, OP_STORE, 4'b0010, 1'b1, ex(3'd1, C_NONE, 4'b0000, 1'b0, 3));
      cyc(0, OP_STORE, 4'b0010, 1'b1, ex(3'd2, C_EXIMM, 4'b0010, 1'b0, 3));
      cyc(0, OP_STORE, 4'b0010, 1'b1, ex(3'd3, C_MEMST, 4'b0000, 1'b1, 3));
      beq(0, 4);

      // I-ALU ANDI, ADDI with funct7[5] set (ignored), R OR
      alu_instr(OP_I, 4'b0111, 4'b0000, 5);
      alu_instr(OP_I, 4'b1000, 4'b0010, 6);
      alu_instr(OP_R, 4'b0110, 4'b0001, 7);

      // async reset in the middle of EXECUTE
      cyc(0, OP_R, 4'b0000, 1'b1, ex(3'd0, C_FRDY, 4'b0010, 1'b0, 8));
      cyc(0, OP_R, 4'b0000, 1'b1, ex(3'd1, C_NONE, 4'b0000, 1'b0, 8));
      @(posedge clk);
      #2;
      checks++;
      if (a_if.state !== 3'd2) begin
         errors++;
         $display("FAIL pre_reset_state got %0d want 2", a_if.state);
      end
      a_if.mem_ready = 1'b0;
      rst_na = 1'b0;
      #1;
      checks++;
      if (a_if.state !== 3'd0 || a_if.instr_count !== 16'd0) begin
         errors++;
         $display("FAIL async_reset got state=%0d cnt=%0d want state=0 cnt=0",
                  a_if.state, a_if.instr_count);
      end
      @(posedge clk);
      #3;
      rst_na = 1'b1;

      // R with unsupported funct traps from EXECUTE
      cyc(0, OP_R, 4'b0001, 1'b1, ex(3'd0, C_FRDY, 4'b0010, 1'b0, 0));
      cyc(0, OP_R, 4'b0001, 1'b1, ex(3'd1, C_NONE, 4'b0000, 1'b0, 0));
      cyc(0, OP_R, 4'b0001, 1'b1, ex(3'd2, C_NONE, 4'b0000, 1'b0, 0));
      for (int i = 0; i < 3; i++)
         cyc(0, OP_R, 4'b0001, 1'b1, ex(3'd5, C_NONE, 4'b0000, 1'b0, 0));
      reset_a();

      // illegal opcode traps after DECODE and stays there
      cyc(0, OP_BAD, 4'b0000, 1'b1, ex(3'd0, C_FRDY, 4'b0010, 1'b0, 0));
      cyc(0, OP_BAD, 4'b0000, 1'b1, ex(3'd1, C_NONE, 4'b0000, 1'b0, 0));
      for (int i = 0; i < 20; i++)
         cyc(0, OP_BAD, 4'b0000, logic'(i % 2), ex(3'd5, C_NONE, 4'b0000, 1'b0, 0));

      // DUT B: stall below the timeout, counter wrap at 2 bits, then fetch timeout
      @(posedge clk);
      #3;
      rst_nb = 1'b1;
      beq(1, 0);
      for (int i = 0; i < 3; i++)
         cyc(1, OP_BEQ, 4'b0000, 1'b0, ex(3'd0, C_FWAIT, 4'b0010, 1'b0, 1));
      beq(1, 1);
      beq(1, 2);
      beq(1, 3);
      for (int i = 0; i < 4; i++)
         cyc(1, OP_BEQ, 4'b0000, 1'b0, ex(3'd0, C_FWAIT, 4'b0010, 1'b0, 0));
      for (int i = 0; i < 3; i++)
         cyc(1, OP_BEQ, 4'b0000, 1'b0, ex(3'd5, C_NONE, 4'b0000, 1'b0, 0));

      @(posedge clk);
      @(posedge clk);
      checks++;
      if (q_a.size() != 0 || q_b.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d/%0d pending want 0/0", q_a.size(), q_b.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
